// File: rtl/control_unit.sv
//==============================================================================
// Module      : control_unit
// Description : Hardwired fetch/execute sequencer that decodes opcode ir[31:27]
//               into datapath bus-source selects, register enables and strobes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        Cout,
    output logic        MARIn,
    output logic        PCIn,
    output logic        MDRIn,
    output logic        IRIn,
    output logic        YIn,
    output logic        ZIn,
    output logic        HiIn,
    output logic        LoIn,
    output logic        CONIn,
    output logic        IncPC,
    output logic        read,
    output logic        write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [3:0]  alu_op,
    output logic        run
);

    localparam logic [3:0] c_ST_RST  = 4'd0;
    localparam logic [3:0] c_ST_T0   = 4'd1;
    localparam logic [3:0] c_ST_T1   = 4'd2;
    localparam logic [3:0] c_ST_T2   = 4'd3;
    localparam logic [3:0] c_ST_T3   = 4'd4;
    localparam logic [3:0] c_ST_T4   = 4'd5;
    localparam logic [3:0] c_ST_T5   = 4'd6;
    localparam logic [3:0] c_ST_T6   = 4'd7;
    localparam logic [3:0] c_ST_T7   = 4'd8;
    localparam logic [3:0] c_ST_HALT = 4'd9;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [4:0] w_op;
    logic [3:0] w_alu_fn;
    logic       w_rtype, w_itype, w_ld, w_ldi, w_st, w_muldiv, w_unary, w_br, w_halt;
    logic       w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_unused_ir = ^ir[26:0];

    assign w_ld     = (w_op == 5'd0);
    assign w_ldi    = (w_op == 5'd1);
    assign w_st     = (w_op == 5'd2);
    assign w_rtype  = (w_op >= 5'd3)  && (w_op <= 5'd10);
    assign w_itype  = (w_op >= 5'd11) && (w_op <= 5'd13);
    assign w_muldiv = (w_op == 5'd14) || (w_op == 5'd15);
    assign w_unary  = (w_op == 5'd16) || (w_op == 5'd17);
    assign w_br     = (w_op == 5'd18);
    assign w_halt   = (w_op == 5'd27);

    // ALU function implied by the opcode; address arithmetic forces add separately
    always_comb begin
        w_alu_fn = 4'd0;
        case (w_op)
            5'd3:  w_alu_fn = 4'd1;
            5'd4:  w_alu_fn = 4'd2;
            5'd5:  w_alu_fn = 4'd3;
            5'd6:  w_alu_fn = 4'd4;
            5'd7:  w_alu_fn = 4'd5;
            5'd8:  w_alu_fn = 4'd6;
            5'd9:  w_alu_fn = 4'd7;
            5'd10: w_alu_fn = 4'd8;
            5'd11: w_alu_fn = 4'd1;
            5'd12: w_alu_fn = 4'd3;
            5'd13: w_alu_fn = 4'd4;
            5'd14: w_alu_fn = 4'd9;
            5'd15: w_alu_fn = 4'd10;
            5'd16: w_alu_fn = 4'd11;
            5'd17: w_alu_fn = 4'd12;
            default: w_alu_fn = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) r_state <= c_ST_RST;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = c_ST_RST;
        case (r_state)
            c_ST_RST: w_next_state = c_ST_T0;
            c_ST_T0:  w_next_state = c_ST_T1;
            c_ST_T1:  w_next_state = c_ST_T2;
            c_ST_T2:  w_next_state = c_ST_T3;
            c_ST_T3: begin
                if (w_halt)
                    w_next_state = c_ST_HALT;
                else if (w_rtype || w_itype || w_ld || w_ldi || w_st || w_muldiv || w_unary || w_br)
                    w_next_state = c_ST_T4;
                else
                    w_next_state = c_ST_T0;
            end
            c_ST_T4:   w_next_state = w_unary ? c_ST_T0 : c_ST_T5;
            c_ST_T5:   w_next_state = (w_ld || w_st || w_muldiv || w_br) ? c_ST_T6 : c_ST_T0;
            c_ST_T6:   w_next_state = (w_ld || w_st) ? c_ST_T7 : c_ST_T0;
            c_ST_T7:   w_next_state = c_ST_T0;
            c_ST_HALT: w_next_state = c_ST_HALT;
            default:   w_next_state = c_ST_RST;
        endcase
    end

    always_comb begin
        {PCout, Zlowout, Zhighout, MDRout, Cout}                          = 5'b0;
        {MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, CONIn, IncPC}    = 10'b0;
        {read, write}                                                     = 2'b0;
        {Gra, Grb, Grc, Rin, Rout, BAout}                                 = 6'b0;
        alu_op = 4'd0;
        run    = (r_state != c_ST_HALT);
        case (r_state)
            c_ST_T0: begin PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; end
            c_ST_T1: begin read = 1'b1; MDRIn = 1'b1; end
            c_ST_T2: begin MDRout = 1'b1; IRIn = 1'b1; end
            c_ST_T3: begin
                if (w_rtype || w_itype) begin Grb = 1'b1; Rout = 1'b1; YIn = 1'b1; end
                else if (w_ld || w_ldi || w_st) begin Grb = 1'b1; BAout = 1'b1; YIn = 1'b1; end
                else if (w_muldiv) begin Gra = 1'b1; Rout = 1'b1; YIn = 1'b1; end
                else if (w_unary) begin Grb = 1'b1; Rout = 1'b1; alu_op = w_alu_fn; ZIn = 1'b1; end
                else if (w_br) begin Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; end
            end
            c_ST_T4: begin
                if (w_rtype) begin Grc = 1'b1; Rout = 1'b1; alu_op = w_alu_fn; ZIn = 1'b1; end
                else if (w_itype) begin Cout = 1'b1; alu_op = w_alu_fn; ZIn = 1'b1; end
                else if (w_ld || w_ldi || w_st) begin Cout = 1'b1; alu_op = 4'd1; ZIn = 1'b1; end
                else if (w_muldiv) begin Grb = 1'b1; Rout = 1'b1; alu_op = w_alu_fn; ZIn = 1'b1; end
                else if (w_unary) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (w_br) begin PCout = 1'b1; YIn = 1'b1; end
            end
            c_ST_T5: begin
                if (w_rtype || w_itype || w_ldi) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (w_ld || w_st) begin Zlowout = 1'b1; MARIn = 1'b1; end
                else if (w_muldiv) begin Zlowout = 1'b1; LoIn = 1'b1; end
                else if (w_br) begin Cout = 1'b1; alu_op = 4'd1; ZIn = 1'b1; end
            end
            c_ST_T6: begin
                if (w_ld) begin read = 1'b1; MDRIn = 1'b1; end
                else if (w_st) begin Gra = 1'b1; Rout = 1'b1; MDRIn = 1'b1; end
                else if (w_muldiv) begin Zhighout = 1'b1; HiIn = 1'b1; end
                else if (w_br && con_ff) begin Zlowout = 1'b1; PCIn = 1'b1; end
            end
            c_ST_T7: begin
                if (w_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (w_st) write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
//==============================================================================
// Module      : tb_control_unit
// Description : Randomized scoreboard bench for control_unit with step-list model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_control_unit;

    typedef struct packed {
        logic       run;
        logic [3:0] alu_op;
        logic PCout, Zlowout, Zhighout, MDRout, Cout;
        logic MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, CONIn, IncPC;
        logic read, write;
        logic Gra, Grb, Grc, Rin, Rout, BAout;
    } ctl_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        con_ff;
    logic PCout, Zlowout, Zhighout, MDRout, Cout;
    logic MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, CONIn, IncPC;
    logic read, write;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic [3:0] alu_op;
    logic run;

    int checks = 0;
    int errors = 0;

    ctl_t  exp_q[$];
    string tag_q[$];
    ctl_t  plan[$];
    bit    plan_halt;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
        .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn), .ZIn(ZIn),
        .HiIn(HiIn), .LoIn(LoIn), .CONIn(CONIn), .IncPC(IncPC),
        .read(read), .write(write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_op(alu_op), .run(run)
    );

    always #5 clk = ~clk;

    // Step description as a list of asserted signal names plus an ALU function
    function automatic ctl_t mk(input string s, input int alu = 0);
        ctl_t  v;
        string t;
        v = '0;
        v.run = 1'b1;
        v.alu_op = alu[3:0];
        t = "";
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s[i] == 8'h20) begin
                if      (t == "PCout")    v.PCout = 1'b1;
                else if (t == "Zlowout")  v.Zlowout = 1'b1;
                else if (t == "Zhighout") v.Zhighout = 1'b1;
                else if (t == "MDRout")   v.MDRout = 1'b1;
                else if (t == "Cout")     v.Cout = 1'b1;
                else if (t == "MARIn")    v.MARIn = 1'b1;
                else if (t == "PCIn")     v.PCIn = 1'b1;
                else if (t == "MDRIn")    v.MDRIn = 1'b1;
                else if (t == "IRIn")     v.IRIn = 1'b1;
                else if (t == "YIn")      v.YIn = 1'b1;
                else if (t == "ZIn")      v.ZIn = 1'b1;
                else if (t == "HiIn")     v.HiIn = 1'b1;
                else if (t == "LoIn")     v.LoIn = 1'b1;
                else if (t == "CONIn")    v.CONIn = 1'b1;
                else if (t == "IncPC")    v.IncPC = 1'b1;
                else if (t == "read")     v.read = 1'b1;
                else if (t == "write")    v.write = 1'b1;
                else if (t == "Gra")      v.Gra = 1'b1;
                else if (t == "Grb")      v.Grb = 1'b1;
                else if (t == "Grc")      v.Grc = 1'b1;
                else if (t == "Rin")      v.Rin = 1'b1;
                else if (t == "Rout")     v.Rout = 1'b1;
                else if (t == "BAout")    v.BAout = 1'b1;
                t = "";
            end else begin
                t = {t, s.substr(i, i)};
            end
        end
        return v;
    endfunction

    // Reference model: the per-cycle control sequence of one whole instruction
    function automatic void build(input logic [4:0] op, input bit con);
        int fn [32];
        plan.delete();
        plan_halt = 1'b0;
        foreach (fn[k]) fn[k] = 0;
        fn[3] = 1; fn[4] = 2; fn[5] = 3; fn[6] = 4; fn[7] = 5; fn[8] = 6; fn[9] = 7; fn[10] = 8;
        fn[11] = 1; fn[12] = 3; fn[13] = 4; fn[14] = 9; fn[15] = 10; fn[16] = 11; fn[17] = 12;
        plan.push_back(mk("PCout MARIn IncPC"));
        plan.push_back(mk("read MDRIn"));
        plan.push_back(mk("MDRout IRIn"));
        if (op >= 3 && op <= 13) begin
            plan.push_back(mk("Grb Rout YIn"));
            plan.push_back(op <= 10 ? mk("Grc Rout ZIn", fn[op]) : mk("Cout ZIn", fn[op]));
            plan.push_back(mk("Zlowout Gra Rin"));
        end else if (op <= 2) begin
            plan.push_back(mk("Grb BAout YIn"));
            plan.push_back(mk("Cout ZIn", 1));
            if (op == 1) plan.push_back(mk("Zlowout Gra Rin"));
            else         plan.push_back(mk("Zlowout MARIn"));
            if (op == 0) begin
                plan.push_back(mk("read MDRIn"));
                plan.push_back(mk("MDRout Gra Rin"));
            end else if (op == 2) begin
                plan.push_back(mk("Gra Rout MDRIn"));
                plan.push_back(mk("write"));
            end
        end else if (op == 14 || op == 15) begin
            plan.push_back(mk("Gra Rout YIn"));
            plan.push_back(mk("Grb Rout ZIn", fn[op]));
            plan.push_back(mk("Zlowout LoIn"));
            plan.push_back(mk("Zhighout HiIn"));
        end else if (op == 16 || op == 17) begin
            plan.push_back(mk("Grb Rout ZIn", fn[op]));
            plan.push_back(mk("Zlowout Gra Rin"));
        end else if (op == 18) begin
            plan.push_back(mk("Gra Rout CONIn"));
            plan.push_back(mk("PCout YIn"));
            plan.push_back(mk("Cout ZIn", 1));
            plan.push_back(con ? mk("Zlowout PCIn") : mk(""));
        end else begin
            plan.push_back(mk(""));
            plan_halt = (op == 5'd27);
        end
    endfunction

    task automatic tick(input ctl_t e, input string tag);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // abort_at >= 0 raises clr right after that step of the instruction
    task automatic run_instr(input logic [31:0] instr, input bit con, input int abort_at);
        ctl_t halted;
        halted = '0;
        build(instr[31:27], con);
        for (int i = 0; i < plan.size(); i++) begin
            tick(plan[i], $sformatf("op%0d_step%0d", instr[31:27], i));
            if (i < 2) begin
                ir = $urandom;
                con_ff = 1'($urandom);
            end else if (i == 2) begin
                ir = instr;
                con_ff = con;
            end
            if (i == abort_at) begin
                clr = 1'b1;
                tick(mk(""), $sformatf("op%0d_abort", instr[31:27]));
                clr = 1'b0;
                return;
            end
        end
        if (plan_halt) begin
            repeat (20) tick(halted, "halted");
            clr = 1'b1;
            tick(mk(""), "halt_clr");
            clr = 1'b0;
        end
    endtask

    ctl_t  m_exp, m_act;
    string m_tag;
    int    m_bus;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            m_exp = exp_q.pop_front();
            m_tag = tag_q.pop_front();
            m_act = {run, alu_op, PCout, Zlowout, Zhighout, MDRout, Cout,
                     MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, CONIn, IncPC,
                     read, write, Gra, Grb, Grc, Rin, Rout, BAout};
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s: got %07h want %07h", m_tag, m_act, m_exp);
            end
            m_bus = int'(PCout) + int'(Zlowout) + int'(Zhighout) + int'(MDRout) + int'(Cout) + int'(Rout);
            checks++;
            if (m_bus > 1 || (read && write)) begin
                errors++;
                $display("FAIL %s_exclusive: bus sources %0d rw %b%b, want <=1 and not both", m_tag, m_bus, read, write);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        int          r;
        logic [4:0]  op;
        logic [4:0]  defined [21];
        clr = 1'b1;
        ir = 32'h0;
        con_ff = 1'b0;
        for (int k = 0; k <= 18; k++) defined[k] = 5'(k);
        defined[19] = 5'd26;
        defined[20] = 5'd27;

        tick(mk(""), "reset0");
        tick(mk(""), "reset1");
        clr = 1'b0;

        run_instr(32'h18000000, 1'b0, -1);
        run_instr(32'h10000000, 1'b0, -1);
        run_instr(32'h90000000, 1'b0, -1);
        run_instr(32'h90000000, 1'b1, -1);
        run_instr(32'h00000000, 1'b0, 5);
        run_instr(32'h10000000, 1'b0, 6);
        run_instr(32'hD8000000, 1'b0, -1);
        run_instr(32'hD0000000, 1'b0, -1);
        run_instr(32'hF8000000, 1'b0, -1);

        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 85) op = defined[$urandom_range(0, 20)];
            else        op = 5'($urandom_range(0, 31));
            run_instr({op, 27'($urandom)}, 1'($urandom),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have: clr  in  1  reset, synchronous and active-high.
REQ-003 SHALL have: ir  in  32  instruction register contents; opcode = ir[31:27].
REQ-004 SHALL have: con_ff  in  1  branch condition from CON flip-flop.
REQ-005 SHALL have: PCout, Zlowout, Zhighout, MDRout, Cout  out  1 each  bus source selects.
REQ-006 SHALL have: MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, CONIn, IncPC  out  1 each  register enables.
REQ-007 SHALL have: read, write  out  1 each  memory strobes.
REQ-008 SHALL have: Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select controls.
REQ-009 SHALL have: alu_op  out  4  ALU function: 0 none, 1 add, 2 sub, 3 and, 4 or, 5 shr, 6 shl, 7 ror, 8 rol, 9 mul, 10 div, 11 neg, 12 not.
REQ-010 SHALL have: run  out  1  high unless halted.

Function
REQ-011 SHALL be a state machine with states RST, T0-T7 and HALT; outputs decode combinationally from state and opcode; any output not listed for a step is 0.
REQ-012 Fetch SHALL be: T0 PCout MARIn IncPC; T1 read MDRIn; T2 MDRout IRIn; T3 begins execution per opcode.
REQ-013 R-type (00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol) SHALL be: T3 Grb Rout YIn; T4 Grc Rout alu_op ZIn; T5 Zlowout Gra Rin; then T0.
REQ-014 I-type (01011 addi=add, 01100 andi=and, 01101 ori=or) SHALL match REQ-013, except T4 uses Cout instead of Grc Rout.
REQ-015 ld (00000) SHALL be: T3 Grb BAout YIn; T4 Cout alu_op=1 ZIn; T5 Zlowout MARIn; T6 read MDRIn; T7 MDRout Gra Rin; then T0.
REQ-016 ldi (00001) SHALL be: T3-T4 as ld; T5 Zlowout Gra Rin; then T0.
REQ-017 st (00010) SHALL be: T3-T5 as ld; T6 Gra Rout MDRIn with read=0; T7 write; then T0.
REQ-018 mul (01110) and div (01111) SHALL be: T3 Gra Rout YIn; T4 Grb Rout alu_op ZIn; T5 Zlowout LoIn; T6 Zhighout HiIn; then T0.
REQ-019 neg (10000) and not (10001) SHALL be: T3 Grb Rout alu_op ZIn; T4 Zlowout Gra Rin; then T0.
REQ-020 branch (10010) SHALL be: T3 Gra Rout CONIn; T4 PCout YIn; T5 Cout alu_op=1 ZIn; T6 Zlowout PCIn only if con_ff=1; then T0.
REQ-021 nop (11010) and every undefined opcode SHALL go from T3 to T0 with all outputs 0 at T3.
REQ-022 halt (11011) SHALL go from T3 to HALT; HALT SHALL hold with all outputs 0 and run=0 until clr.
REQ-023 read and write SHALL never be high in the same cycle; write SHALL be high only in st T7.
REQ-024 Exactly one bus source (PCout, Zlowout, Zhighout, MDRout, Cout, Rout) SHALL be high in any cycle, or none.
REQ-025 opcode SHALL be sampled only from T3 onward; ir changes during T0-T2 SHALL NOT affect fetch.

Reset
REQ-026 clr=1 at a rising edge SHALL force state RST, with all control outputs 0 and run=1, regardless of current state, including HALT and mid-instruction.
REQ-027 Leaving RST SHALL go to T0 on the first edge with clr=0; an abandoned st SHALL NOT assert write after clr.

Verification
REQ-028 Reset: clr high 2 cycles, then low -> outputs all 0 during RST; next cycle T0 shows PCout=MARIn=IncPC=1.
REQ-029 add: ir=0x18000000 -> T3 Grb/Rout/YIn, T4 Grc/Rout/alu_op=1/ZIn, T5 Zlowout/Gra/Rin, T6 is T0; 6 cycles total.
REQ-030 st: ir=0x10000000 -> write=1 only in T7, read=0 in T6 and T7; next cycle is T0.
REQ-031 branch: ir=0x90000000 with con_ff=0 -> T6 has PCin=0; repeat with con_ff=1 -> T6 has Zlowout=PCIn=1.
REQ-032 halt: ir=0xD8000000 -> run=0 from the cycle after T3 and stays 0 for 20 cycles; clr -> RST, run=1.
REQ-033 Mid-op reset: assert clr during ld T5 -> next state RST, no read/MDRIn pulse at T6.
